// File: rtl/branch_predictor_f.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters,
// trained from Execute, with saturating branch/mispredict performance counters.
module branch_predictor_f #(
  parameter int unsigned INDEX_BITS = 4,
  parameter logic [1:0]  CNT_ALLOC  = 2'b10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PCF,
  output logic        PrPCSrcF,
  output logic [31:0] PrBTAF,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic        StallE,
  input  logic [31:0] PCE,
  input  logic        PCSrcE,
  input  logic [31:0] BTAE,
  input  logic        PrPCSrcE,
  input  logic [31:0] PrBTAE,
  output logic        MispredictE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;

  logic                valid  [ENTRIES];
  logic [TAG_BITS-1:0] tag    [ENTRIES];
  logic [31:0]         target [ENTRIES];
  logic [1:0]          cnt    [ENTRIES];

  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e, upd;
  logic                  unused_pc_low;

  // Word-aligned PCs: the two low bits never participate in lookup or training.
  assign unused_pc_low = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[INDEX_BITS+1:2];
  assign tag_f = PCF[31:INDEX_BITS+2];
  assign idx_e = PCE[INDEX_BITS+1:2];
  assign tag_e = PCE[31:INDEX_BITS+2];

  always_comb begin
    hit_f    = valid[idx_f] && (tag[idx_f] == tag_f);
    hit_e    = valid[idx_e] && (tag[idx_e] == tag_e);
    PrPCSrcF = hit_f && cnt[idx_f][1];
    PrBTAF   = hit_f ? target[idx_f] : '0;
  end

  assign upd         = (BranchE || JumpE) && !StallE;
  assign MispredictE = upd && ((PrPCSrcE != PCSrcE) ||
                               (PCSrcE && PrPCSrcE && (PrBTAE != BTAE)));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        cnt[i]    <= 2'b01;
      end
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd) begin
      if (JumpE) begin
        valid[idx_e]  <= 1'b1;
        tag[idx_e]    <= tag_e;
        target[idx_e] <= BTAE;
        cnt[idx_e]    <= 2'b11;
      end else if (hit_e) begin
        if (PCSrcE) begin
          target[idx_e] <= BTAE;
          if (cnt[idx_e] != 2'b11) cnt[idx_e] <= cnt[idx_e] + 2'd1;
        end else begin
          if (cnt[idx_e] != 2'b00) cnt[idx_e] <= cnt[idx_e] - 2'd1;
        end
      end else if (PCSrcE) begin
        valid[idx_e]  <= 1'b1;
        tag[idx_e]    <= tag_e;
        target[idx_e] <= BTAE;
        cnt[idx_e]    <= CNT_ALLOC;
      end
      if (branch_count != '1) branch_count <= branch_count + 32'd1;
      if (MispredictE && (mispredict_count != '1))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

  assign BranchCount     = branch_count;
  assign MispredictCount = mispredict_count;

endmodule

// File: doc/branch_predictor_f.md
Name: branch_predictor_f

Overview:
- Fetch-stage dynamic branch predictor: direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters.
- Looks up PCF combinationally and produces PrPCSrcF/PrBTAF. The IF/ID register carries these into Decode and on to Execute.
- Trained from Execute with the resolved outcome. Flags mispredictions for the hazard unit.
- Keeps branch and mispredict performance counters.

Parameters:
- INDEX_BITS, 4, log2 of BTB entry count (16 entries)
- CNT_ALLOC, 2'b10, counter value written on allocation of a taken conditional branch

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- PCF  in  32  fetch PC to look up
- PrPCSrcF  out  1  predicted taken
- PrBTAF  out  32  predicted target
- BranchE  in  1  Execute holds a conditional branch
- JumpE  in  1  Execute holds an unconditional jump (JAL/JALR)
- StallE  in  1  Execute stalled; suppresses update and counting
- PCE  in  32  PC of the Execute instruction
- PCSrcE  in  1  resolved taken
- BTAE  in  32  resolved target
- PrPCSrcE  in  1  prediction made for this instruction (piped through D/E)
- PrBTAE  in  32  predicted target (piped through D/E)
- MispredictE  out  1  prediction wrong; redirect and flush required
- BranchCount  out  32  resolved branches and jumps
- MispredictCount  out  32  mispredictions

Behaviour:
- Index = PC[INDEX_BITS+1:2]. Tag = PC[31:INDEX_BITS+2]. Each entry holds valid, tag, target[31:0] and cnt[1:0].
- Lookup (combinational, zero latency):
  - hit = valid[idxF] && tag[idxF]==PCF tag
  - PrPCSrcF = hit && cnt[idxF][1]
  - PrBTAF = hit ? target[idxF] : 32'b0
- Resolve (combinational):
  - Let U = (BranchE|JumpE) && !StallE.
  - MispredictE = U && ((PrPCSrcE != PCSrcE) || (PCSrcE && PrPCSrcE && PrBTAE != BTAE)).
  - MispredictE is 0 whenever U=0.
- Update at posedge CLK when U=1, on entry idxE = PCE index. If both BranchE and JumpE are asserted, JumpE takes priority.
  - JumpE: valid←1, tag←PCE tag, target←BTAE, cnt←2'b11, regardless of hit.
  - BranchE with entry hit and PCSrcE=1: cnt←min(cnt+1,3), target←BTAE.
  - BranchE with entry hit and PCSrcE=0: cnt←max(cnt-1,0). Target and valid are unchanged; the entry stays valid at cnt=0.
  - BranchE with entry miss and PCSrcE=1: allocate and overwrite any prior entry. valid←1, tag←PCE tag, target←BTAE, cnt←CNT_ALLOC.
  - BranchE with entry miss and PCSrcE=0: no change.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents (no bypass). The new contents are visible from the next cycle.
- Counters, at posedge when U=1:
  - BranchCount += 1
  - MispredictCount += MispredictE
  - Both saturate at 32'hFFFFFFFF (no wrap).
- Reset:
  - All valid←0, cnt←2'b01, tag←0, target←0.
  - BranchCount←0, MispredictCount←0.
  - Consequence: PrPCSrcF=0, PrBTAF=0 and MispredictE=0 for any input while tables are invalid and E inputs are idle.
  - RESET overrides a simultaneous update. A mid-run reset discards all training.
- X-safety: PCF[1:0] and PCE[1:0] are ignored.
- Storage: flip-flops (registers), not inferred RAM, so that reset clears them. Roughly 2^INDEX_BITS × (1 + tag + 32 + 2) bits.

Test Plan:
- Reset, then PCF=0x00000040 → PrPCSrcF=0, PrBTAF=0. Counters read 0.
- BranchE=1, PCE=0x40, PCSrcE=1, BTAE=0x80, PrPCSrcE=0 → MispredictE=1 that cycle. Next cycle PCF=0x40 → PrPCSrcF=1, PrBTAF=0x80. BranchCount=1, MispredictCount=1.
- Resolve the same branch not-taken twice:
  - cnt goes 10→01→00; PrPCSrcF=0 after the first update.
  - Then taken once: cnt=01, still predicts not-taken.
  - Then taken again: cnt=10, predicts taken.
- Aliasing: train PCE=0x40 taken, then JumpE at PCE=0x80 (same index, different tag) with BTAE=0x200 → lookup at 0x40 misses (PrPCSrcF=0); lookup at 0x80 gives PrBTAF=0x200.
- Same-cycle conflict: PCF=0x40 with update to 0x40 in the same cycle → old prediction that cycle, new one the next. StallE=1 with BranchE=1 → no table or counter change, MispredictE=0.
- Correct-direction, wrong-target case: PrPCSrcE=1, PrBTAE=0x80, PCSrcE=1, BTAE=0x90 → MispredictE=1 and target updated to 0x90. Separately, force MispredictCount to 0xFFFFFFFF and mispredict → value holds at 0xFFFFFFFF.
